// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial add/subtract controller.
package serial_adder_ctrl_pkg;

   // Default operand/result width.
   localparam int unsigned DefaultWidth = 8;

   // Controller states; 2'd3 is unused and recovers to StIdle.
   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

endpackage

// File: rtl/serial_adder_ctrl_fa.sv
// One-bit full-adder cell.
module serial_adder_ctrl_fa (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   // Sum and carry of three one-bit inputs.
   always_comb begin
      s  = a ^ b ^ ci;
      co = (a & b) | (a & ci) | (b & ci);
   end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller: operands are shifted LSB-first through a
// single full-adder cell, one bit per clock, with a registered carry.
module serial_adder_ctrl
   import serial_adder_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

   state_e           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   // Upper WIDTH-1 result bits collected so far; the final bit comes straight from the cell.
   logic [WIDTH-2:0] acc;
   logic             carry;
   logic [CntW-1:0]  cnt;
   logic             s;
   logic             c;
   logic [WIDTH-1:0] acc_sh;

   serial_adder_ctrl_fa u_fa (
      .a  (a_sh[0]),
      .b  (b_sh[0]),
      .ci (carry),
      .s  (s),
      .co (c)
   );

   // New sum bit enters at the MSB; after WIDTH shifts this is the full result.
   always_comb begin
      acc_sh = {s, acc};
   end

   // FSM, datapath shift registers and registered result outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= StIdle;
         a_sh  <= '0;
         b_sh  <= '0;
         acc   <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         case (state)
            StIdle: begin
               if (start) begin
                  a_sh  <= a;
                  // Subtraction is a + ~b + 1.
                  b_sh  <= sub ? ~b : b;
                  carry <= sub ? 1'b1 : cin;
                  cnt   <= '0;
                  state <= StRun;
               end
            end
            StRun: begin
               acc   <= acc_sh[WIDTH-1:1];
               a_sh  <= a_sh >> 1;
               b_sh  <= b_sh >> 1;
               carry <= c;
               cnt   <= cnt + 1'b1;
               if (cnt == CntLast) begin
                  sum   <= acc_sh;
                  cout  <= c;
                  // carry currently holds the carry into the MSB.
                  ovf   <= carry ^ c;
                  state <= StDone;
               end
            end
            StDone: begin
               state <= StIdle;
            end
            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

   // Status flags decoded from registered state only.
   assign busy = (state == StRun);
   assign done = (state == StDone);

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH = 8).
module tb_serial_adder_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         sub;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .sub   (sub),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout),
      .ovf   (ovf)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Model: timing as edge numbers, results from plain arithmetic.
   int           edge_n    = 0;
   int           run_from  = -1000;
   int           done_edge = -1;
   int           free_edge = 0;
   logic [W-1:0] m_sum;
   logic         m_cout;
   logic         m_ovf;
   logic [W-1:0] p_sum;
   logic         p_cout;
   logic         p_ovf;

   // Observation bookkeeping for literal checks.
   int done_cnt  = 0;
   int busy_seen = 0;
   int last_done = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
      end
   endtask

   // Advance one clock: update the model from the inputs sampled at the edge,
   // then compare every output against it on the falling edge.
   task automatic step();
      logic [W-1:0] b_eff;
      logic [W:0]   full;
      logic         c0;
      @(posedge clk);
      edge_n++;
      if (rst) begin
         m_sum     = '0;
         m_cout    = 1'b0;
         m_ovf     = 1'b0;
         run_from  = -1000;
         done_edge = -1;
         free_edge = edge_n + 1;
      end else begin
         if (edge_n == done_edge) begin
            m_sum  = p_sum;
            m_cout = p_cout;
            m_ovf  = p_ovf;
         end
         if (edge_n >= free_edge && start) begin
            b_eff     = sub ? ~b : b;
            c0        = sub ? 1'b1 : cin;
            full      = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, c0};
            p_sum     = full[W-1:0];
            p_cout    = full[W];
            p_ovf     = (a[W-1] == b_eff[W-1]) && (full[W-1] != a[W-1]);
            run_from  = edge_n;
            done_edge = edge_n + W;
            free_edge = edge_n + W + 2;
         end
      end
      @(negedge clk);
      chk("busy", {31'd0, busy}, {31'd0, (edge_n >= run_from) && (edge_n < run_from + W)});
      chk("done", {31'd0, done}, {31'd0, edge_n == done_edge});
      chk("sum", {24'd0, sum}, {24'd0, m_sum});
      chk("cout", {31'd0, cout}, {31'd0, m_cout});
      chk("ovf", {31'd0, ovf}, {31'd0, m_ovf});
      if (busy) busy_seen++;
      if (done) begin
         done_cnt++;
         last_done = edge_n;
      end
   endtask

   // Issue one operation, wait (bounded) for done, then return to IDLE.
   task automatic run_op(input logic s_i, input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                         input logic c_i, output int lat);
      sub   = s_i;
      a     = a_i;
      b     = b_i;
      cin   = c_i;
      start = 1'b1;
      busy_seen = 0;
      step();
      start = 1'b0;
      lat = 1;
      while (!done && lat < 40) begin
         step();
         lat++;
      end
      if (!done) chk("done_timeout", 32'd0, 32'd1);
      step();
   endtask

   initial begin
      int lat;
      int d0;
      int t1;
      int t2;
      rst   = 1'b1;
      start = 1'b0;
      sub   = 1'b0;
      a     = '0;
      b     = '0;
      cin   = 1'b0;
      @(negedge clk);
      step();
      step();
      chk("reset_sum", {24'd0, sum}, 32'h0);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      rst = 1'b0;
      step();

      // 1: basic add with signed overflow, latency and busy length.
      run_op(1'b0, 8'h5A, 8'h3C, 1'b0, lat);
      chk("t1_latency", lat, 32'd9);
      chk("t1_busy_cycles", busy_seen, 32'd8);
      chk("t1_sum", {24'd0, sum}, 32'h96);
      chk("t1_cout", {31'd0, cout}, 32'd0);
      chk("t1_ovf", {31'd0, ovf}, 32'd1);

      // 2: carry out, then carry-in only.
      run_op(1'b0, 8'hFF, 8'h01, 1'b0, lat);
      chk("t2a_sum", {24'd0, sum}, 32'h00);
      chk("t2a_cout", {31'd0, cout}, 32'd1);
      chk("t2a_ovf", {31'd0, ovf}, 32'd0);
      run_op(1'b0, 8'h00, 8'h00, 1'b1, lat);
      chk("t2b_sum", {24'd0, sum}, 32'h01);
      chk("t2b_cout", {31'd0, cout}, 32'd0);

      // 3: subtraction with borrow, then with signed overflow.
      run_op(1'b1, 8'h10, 8'h20, 1'b1, lat);
      chk("t3a_sum", {24'd0, sum}, 32'hF0);
      chk("t3a_cout", {31'd0, cout}, 32'd0);
      chk("t3a_ovf", {31'd0, ovf}, 32'd0);
      run_op(1'b1, 8'h80, 8'h01, 1'b0, lat);
      chk("t3b_sum", {24'd0, sum}, 32'h7F);
      chk("t3b_cout", {31'd0, cout}, 32'd1);
      chk("t3b_ovf", {31'd0, ovf}, 32'd1);

      // 4: start re-asserted with new operands during RUN and DONE is ignored.
      sub   = 1'b0;
      cin   = 1'b0;
      a     = 8'h01;
      b     = 8'h01;
      start = 1'b1;
      d0    = done_cnt;
      step();
      a = 8'hAA;
      b = 8'h55;
      for (int i = 0; i < W + 1; i++) step();
      start = 1'b0;
      for (int i = 0; i < 12; i++) step();
      chk("t4_done_count", done_cnt - d0, 32'd1);
      chk("t4_sum", {24'd0, sum}, 32'h02);

      // 5: start held high; completions every WIDTH+2 cycles.
      sub   = 1'b0;
      a     = 8'h33;
      b     = 8'h44;
      cin   = 1'b1;
      start = 1'b1;
      d0    = done_cnt;
      t1    = 0;
      t2    = 0;
      for (int i = 0; i < 60 && (done_cnt - d0) < 3; i++) begin
         step();
         if (done && (done_cnt - d0) == 2) t1 = last_done;
         if (done && (done_cnt - d0) == 3) t2 = last_done;
      end
      start = 1'b0;
      chk("t5_done_pulses", done_cnt - d0, 32'd3);
      chk("t5_spacing", t2 - t1, 32'd10);
      chk("t5_sum", {24'd0, sum}, 32'h78);
      step();

      // 6: reset mid-RUN aborts with no done pulse.
      sub   = 1'b0;
      a     = 8'h5A;
      b     = 8'h3C;
      cin   = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      step();
      rst = 1'b1;
      d0  = done_cnt;
      step();
      rst = 1'b0;
      chk("t6_busy", {31'd0, busy}, 32'd0);
      chk("t6_done", {31'd0, done}, 32'd0);
      chk("t6_sum", {24'd0, sum}, 32'h0);
      chk("t6_cout", {31'd0, cout}, 32'd0);
      chk("t6_ovf", {31'd0, ovf}, 32'd0);
      for (int i = 0; i < W + 4; i++) step();
      chk("t6_no_done", done_cnt - d0, 32'd0);
      run_op(1'b1, 8'h05, 8'h07, 1'b0, lat);
      chk("t6_sum_after", {24'd0, sum}, 32'hFE);
      chk("t6_cout_after", {31'd0, cout}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial add/subtract controller built around one one-bit full-adder cell.
- Accepts two WIDTH-bit operands on a start pulse.
- Shifts the operands LSB-first through the cell, one bit per clock, with a registered carry.
- Returns the sum, carry-out and signed overflow with a one-cycle done pulse.
- Sits between the ALU register file and the status flags. It trades latency for area against a WIDTH-wide ripple adder.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
sub  input  1  0 = add, 1 = subtract (a - b); sampled with start
a  input  WIDTH  operand A; sampled with start
b  input  WIDTH  operand B; sampled with start
cin  input  1  carry-in for add; ignored when sub=1; sampled with start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse; results valid
sum  output  WIDTH  result register
cout  output  1  final carry-out (sub: 1 = no borrow)
ovf  output  1  signed two's-complement overflow

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, bit counter=0.
  - Internal shift registers and carry flop are cleared.
  - Reset overrides every other input.
- States are IDLE, RUN and DONE.
- IDLE:
  - Loads happen at the edge where start=1.
  - a_sh <= a; b_sh <= sub ? ~b : b; carry <= sub ? 1 : cin; cnt <= 0; state -> RUN.
  - start=0 keeps the block in IDLE.
- RUN, each cycle:
  - The cell computes s and c from (a_sh[0], b_sh[0], carry).
  - acc <= {s, acc[WIDTH-1:1]}; a_sh and b_sh shift right by 1; carry <= c; cnt <= cnt+1.
  - When cnt = WIDTH-1, the carry into the cell is latched as c_msb_in.
  - The same edge sets sum <= {s, acc[WIDTH-1:1]}, cout <= c, ovf <= c_msb_in ^ c, and state -> DONE.
  - RUN lasts exactly WIDTH cycles.
- DONE:
  - done=1 for exactly one cycle, then state -> IDLE unconditionally.
  - start is ignored in DONE.
- busy = (state==RUN); done = (state==DONE). Both are decoded from registered state, so there is no combinational input-to-output path.
- Latency:
  - start edge at cycle k gives done high in cycle k+WIDTH+1.
  - Minimum start-to-start spacing is WIDTH+2 cycles.
  - With start held high continuously, one operation completes every WIDTH+2 cycles.
- sum, cout and ovf hold their last values until the next completion. They are not cleared at start.
- start, a, b, sub and cin changing during RUN or DONE have no effect. Operands are captured only at the accepting edge.
- Reset mid-RUN aborts the operation: no done pulse, and outputs return to reset values.
- Counter width is clog2(WIDTH). Subtraction is a + ~b + 1, and cout=0 indicates a borrow.

Decomposition:
- Shared package holds:
  - the state encoding constants IDLE=2'd0, RUN=2'd1, DONE=2'd2; 2'd3 is illegal and recovers to IDLE;
  - the default WIDTH constant.
- One sub-module: the team's existing one-bit full-adder cell, instantiated once for the s/c computation.
- Shift registers, counter and FSM stay in serial_adder_ctrl.

Test Plan:
1. WIDTH=8, add, a=0x5A, b=0x3C, cin=0 -> done exactly 9 cycles after start edge; sum=0x96, cout=0, ovf=1; busy high for 8 cycles.
2. Add, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Then a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0, ovf=0.
3. Sub, a=0x10, b=0x20, cin=1 (ignored) -> sum=0xF0, cout=0 (borrow), ovf=0. Then sub a=0x80, b=0x01 -> sum=0x7F, cout=1, ovf=1.
4. Start pulse with a=0x01, b=0x01; re-assert start with a=0xAA, b=0x55 during RUN and during DONE -> single result sum=0x02; no second done until a new start in IDLE.
5. Start held high continuously with fixed operands -> done pulses spaced exactly 10 cycles apart; sum stable between pulses.
6. rst asserted at RUN cycle 4 -> next cycle busy=0, done=0, sum=0, cout=0, ovf=0; no done pulse appears. A new start then completes normally with correct results.
